spi_reg_slave: RTL and testbench
================================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 The block SHALL have parameter CSpiMode, default 0, meaning SPI mode 0..3: bit1 = CPOL (SCK idle level), bit0 = CPHA.
REQ-002 The block SHALL have parameter CNcsPol, default 0, meaning NCS active level (0 = active low).
REQ-003 AClkH  input  1  the single clock; all state changes on its rising edge.
REQ-004 AResetH  input  1  reset; synchronous and active-high.
REQ-005 ASckI  input  1  SPI clock from the external master; asynchronous to AClkH.
REQ-006 ANcsI  input  1  SPI chip select from the external master; asynchronous.
REQ-007 AMosi  input  1  serial data from the master, MSB first.
REQ-008 AMiso  output  1  serial data to the master, MSB first.
REQ-009 AMisoE  output  1  MISO output enable; 1 while the synchronized NCS is active.
REQ-010 ARegAddr  output  7  register address for the current write or read strobe.
REQ-011 ARegWrData  output  8  write data; valid while ARegWrEn=1.
REQ-012 ARegWrEn  output  1  one-cycle register write strobe.
REQ-013 ARegRdEn  output  1  one-cycle register read strobe.
REQ-014 ARegRdData  input  8  read data; valid exactly 1 AClkH cycle after ARegRdEn.
REQ-015 ABusy  output  1  1 while a frame is in progress (synchronized NCS active).
REQ-016 AAbort  output  1  one-cycle pulse when NCS deasserts mid-byte.

Function
REQ-017 ASckI, ANcsI and AMosi SHALL each pass through a 2-flop synchronizer before use; SCK edges are detected on the synchronized value.
REQ-018 After the synchronizer, SCK SHALL be XORed with CPOL. The sample edge is the rising edge when CPHA=0 and the falling edge when CPHA=1; the other edge is the shift edge.
REQ-019 Timing envelope: SCK high and low phases SHALL each be at least 6 AClkH cycles; NCS setup and hold to SCK SHALL each be at least 4 cycles. Behaviour outside this envelope is undefined.
REQ-020 The FSM SHALL have four states: IDLE, CMD, WR, RD. NCS becoming active moves IDLE to CMD and clears the 3-bit bit counter and the shift registers.
REQ-021 On each sample edge, the receive shift register SHALL take {rx[6:0], MOSI} and the bit counter SHALL increment modulo 8. A byte completes when the counter wraps from 7 to 0.
REQ-022 On CMD byte completion, the FSM SHALL latch the address = byte[6:0]. If byte[7]=0 it goes to WR. If byte[7]=1 it goes to RD and pulses ARegRdEn with that address in the cycle after completion.
REQ-023 In WR, each completed byte SHALL produce ARegWrEn=1 for 1 cycle, one cycle after completion, with the current ARegAddr and ARegWrData = byte. The address then increments.
REQ-024 In RD, ARegRdData SHALL be loaded into the transmit shift register in the cycle after ARegRdEn. On each RD byte completion, the address SHALL increment and ARegRdEn SHALL pulse again as a prefetch, so one extra read occurs at frame end.
REQ-025 The address SHALL increment as 7-bit modulo arithmetic: 0x7F wraps to 0x00.
REQ-026 On each shift edge the transmit register SHALL shift left, and AMiso SHALL equal tx[7].
REQ-027 For CPHA=0, a freshly loaded byte SHALL drive its MSB immediately. For CPHA=1, the MSB SHALL appear on the first shift edge.
REQ-028 During the CMD byte and during WR, AMiso SHALL be 0.
REQ-029 ARegWrEn and ARegRdEn SHALL never be asserted in the same cycle.
REQ-030 ARegAddr SHALL hold its value between strobes.
REQ-031 NCS becoming inactive in any state SHALL return the FSM to IDLE on the next cycle and discard any partial byte with no strobe. AAbort SHALL pulse for 1 cycle if the bit counter is not 0.
REQ-032 If NCS deasserts in the same cycle a byte completes, the pending strobe for that completed byte SHALL still be issued and AAbort SHALL not pulse.
REQ-033 A frame SHALL contain a command byte only: CMD then NCS inactive gives no write; a read command still issues its single prefetch.
REQ-034 SCK edges while NCS is inactive SHALL be ignored.

Reset
REQ-035 While AResetH=1 at a clock edge, the FSM SHALL be IDLE and the bit counter, shift registers and synchronizers SHALL be cleared to 0 (NCS synchronizer to the inactive level). All outputs SHALL be 0: AMiso, AMisoE, ARegAddr, ARegWrData, ARegWrEn, ARegRdEn, ABusy, AAbort.
REQ-036 Reset asserted mid-frame SHALL abort the frame without a strobe and without AAbort. After reset release, the next NCS activation SHALL be needed before a new frame starts.

Verification
REQ-037 Mode 0 write: MOSI 0x05,0xA1,0xB2 -> ARegWrEn twice, (0x05,0xA1) then (0x06,0xB2); no ARegRdEn.
REQ-038 Mode 0 read: MOSI 0x90, RdData returns 0x3C at 0x10 and 0x5A at 0x11 -> MISO bytes 0x00,0x3C,0x5A; ARegRdEn at 0x10, 0x11, 0x12.
REQ-039 Wrap: write command 0x7F with data 0x11,0x22 -> writes at 0x7F then 0x00.
REQ-040 Abort: NCS deasserted after 3 bits of the second byte of a write frame -> no ARegWrEn for that byte, AAbort single pulse, ABusy falls, FSM IDLE.
REQ-041 Mode 3 (CPOL=1,CPHA=1): read command 0x81 with RdData 0xC3 -> MISO 0xC3 with MSB on first shift edge; repeat with mode 1 and mode 2.
REQ-042 Reset mid-read frame -> all outputs 0 next cycle; SCK toggles with NCS still active after release -> no strobes.

Source files
------------

// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_slave
// Purpose  : SPI slave that converts SPI frames into register-bus strobes.
//            A frame starts with a command byte {rd, addr[6:0]}. A write
//            frame turns each following byte into a write strobe. A read
//            frame prefetches register data and shifts it out on MISO. The
//            address auto-increments modulo 128 in both cases.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CSpiMode   SPI mode 0..3 (bit1 = CPOL, bit0 = CPHA)
//   CNcsPol    NCS active level (0 = active low)
// Ports
//   AClkH       in   1  clock, all state changes on its rising edge
//   AResetH     in   1  synchronous active-high reset
//   ASckI       in   1  SPI clock (asynchronous)
//   ANcsI       in   1  SPI chip select (asynchronous)
//   AMosi       in   1  serial data in, MSB first
//   AMiso       out  1  serial data out, MSB first
//   AMisoE      out  1  MISO output enable (frame active)
//   ARegAddr    out  7  register address for the current strobe
//   ARegWrData  out  8  write data, valid with ARegWrEn
//   ARegWrEn    out  1  one-cycle write strobe
//   ARegRdEn    out  1  one-cycle read strobe
//   ARegRdData  in   8  read data, valid one cycle after ARegRdEn
//   ABusy       out  1  frame in progress
//   AAbort      out  1  one-cycle pulse when NCS deasserts mid-byte
// ============================================================================
module spi_reg_slave #(
  parameter int   CSpiMode = 0,
  parameter logic CNcsPol  = 1'b0
) (
  input  logic       AClkH,
  input  logic       AResetH,
  input  logic       ASckI,
  input  logic       ANcsI,
  input  logic       AMosi,
  output logic       AMiso,
  output logic       AMisoE,
  output logic [6:0] ARegAddr,
  output logic [7:0] ARegWrData,
  output logic       ARegWrEn,
  output logic       ARegRdEn,
  input  logic [7:0] ARegRdData,
  output logic       ABusy,
  output logic       AAbort
);

  localparam logic c_CPOL     = ((CSpiMode / 2) % 2) == 1;
  localparam logic c_CPHA     = (CSpiMode % 2) == 1;
  localparam logic c_NCS_IDLE = ~CNcsPol;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WR   = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  // Input synchronizers
  logic       r_sck_s1, r_sck_s2, r_sck_prev;
  logic       r_ncs_s1, r_ncs_s2;
  logic       r_mosi_s1, r_mosi_s2;

  // A frame may only start after NCS has been seen inactive with a fully
  // refilled synchronizer, so NCS held active across reset cannot start one.
  logic [1:0] r_vld;
  logic       r_armed;

  logic [2:0] r_bitcnt;
  logic [6:0] r_rx;
  logic [7:0] r_tx;
  logic       r_fresh;
  logic       r_miso_q;
  logic [6:0] r_addr;
  logic [7:0] r_wr_data;
  logic       r_wr_en;
  logic       r_rd_en;
  logic       r_rd_en_d;
  logic       r_abort;
  logic       r_busy;

  logic       w_sck;
  logic       w_rise, w_fall;
  logic       w_sample, w_shift;
  logic       w_act;
  logic       w_in_frame;
  logic       w_done;
  logic [7:0] w_byte;
  logic       w_start;
  logic       w_wr_pulse;
  logic       w_rd_pulse;
  logic       w_addr_load;
  logic       w_abort;

  // Logical SCK: idle level always 0, so "rise" is the leading edge.
  assign w_sck      = r_sck_s2 ^ c_CPOL;
  assign w_rise     = w_sck & ~r_sck_prev;
  assign w_fall     = ~w_sck & r_sck_prev;
  assign w_sample   = c_CPHA ? w_fall : w_rise;
  assign w_shift    = c_CPHA ? w_rise : w_fall;
  assign w_act      = (r_ncs_s2 == CNcsPol);
  assign w_in_frame = (r_state != ST_IDLE);
  // Completion is recognised even in the cycle NCS is seen inactive so that
  // a byte finishing together with deassertion still produces its strobe.
  assign w_done     = w_in_frame & w_sample & (r_bitcnt == 3'd7);
  assign w_byte     = {r_rx, r_mosi_s2};

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and strobe decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_wr_pulse  = 1'b0;
    w_rd_pulse  = 1'b0;
    w_addr_load = 1'b0;
    w_abort     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_act && r_armed) begin
          w_state_nxt = ST_CMD;
          w_start     = 1'b1;
        end
      end
      ST_CMD: begin
        if (w_done) begin
          w_addr_load = 1'b1;
          if (w_byte[7]) begin
            w_state_nxt = ST_RD;
            w_rd_pulse  = 1'b1;
          end else begin
            w_state_nxt = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (w_done) begin
          w_wr_pulse = 1'b1;
        end
      end
      ST_RD: begin
        // Prefetch the next register as soon as the current byte is done.
        if (w_done) begin
          w_rd_pulse = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_in_frame && !w_act) begin
      w_state_nxt = ST_IDLE;
      w_abort     = (r_bitcnt != 3'd0) && !w_done;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      r_sck_s1   <= 1'b0;
      r_sck_s2   <= 1'b0;
      r_sck_prev <= c_CPOL;
      r_ncs_s1   <= c_NCS_IDLE;
      r_ncs_s2   <= c_NCS_IDLE;
      r_mosi_s1  <= 1'b0;
      r_mosi_s2  <= 1'b0;
      r_vld      <= 2'b00;
      r_armed    <= 1'b0;
      r_bitcnt   <= 3'd0;
      r_rx       <= 7'd0;
      r_tx       <= 8'd0;
      r_fresh    <= 1'b0;
      r_miso_q   <= 1'b0;
      r_addr     <= 7'd0;
      r_wr_data  <= 8'd0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_en_d  <= 1'b0;
      r_abort    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sck_s1   <= ASckI;
      r_sck_s2   <= r_sck_s1;
      r_sck_prev <= w_sck;
      r_ncs_s1   <= ANcsI;
      r_ncs_s2   <= r_ncs_s1;
      r_mosi_s1  <= AMosi;
      r_mosi_s2  <= r_mosi_s1;
      r_vld      <= {r_vld[0], 1'b1};
      r_armed    <= r_armed | (r_vld[1] & ~w_act);

      r_wr_en    <= w_wr_pulse;
      r_rd_en    <= w_rd_pulse;
      r_rd_en_d  <= r_rd_en;
      r_abort    <= w_abort;
      r_busy     <= (w_state_nxt != ST_IDLE);

      if (w_wr_pulse) begin
        r_wr_data <= w_byte;
      end

      // Reads advance the address together with the prefetch strobe; writes
      // advance it after the strobe has presented the current address.
      if (w_addr_load) begin
        r_addr <= w_byte[6:0];
      end else if ((r_state == ST_RD) && w_done) begin
        r_addr <= r_addr + 7'd1;
      end else if (r_wr_en) begin
        r_addr <= r_addr + 7'd1;
      end

      if (w_start) begin
        r_bitcnt <= 3'd0;
        r_rx     <= 7'd0;
      end else if (w_in_frame && w_sample) begin
        r_rx     <= w_byte[6:0];
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      // With CPHA=0 the loaded MSB is already on MISO; the shift edge that
      // closes the previous byte must not consume it, hence r_fresh.
      if (w_start) begin
        r_tx     <= 8'd0;
        r_fresh  <= 1'b0;
        r_miso_q <= 1'b0;
      end else if (r_rd_en_d) begin
        r_tx     <= ARegRdData;
        r_fresh  <= 1'b1;
      end else if (w_in_frame && w_act && w_shift) begin
        if (!c_CPHA && r_fresh) begin
          r_fresh <= 1'b0;
        end else begin
          r_miso_q <= r_tx[7];
          r_tx     <= {r_tx[6:0], 1'b0};
        end
      end
    end
  end

  assign AMiso      = (r_state == ST_RD) & (c_CPHA ? r_miso_q : r_tx[7]);
  assign AMisoE     = r_busy;
  assign ABusy      = r_busy;
  assign ARegAddr   = r_addr;
  assign ARegWrData = r_wr_data;
  assign ARegWrEn   = r_wr_en;
  assign ARegRdEn   = r_rd_en;
  assign AAbort     = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_slave
// Purpose  : Self-checking bench for spi_reg_slave. Four instances cover SPI
//            modes 0..3 (mode 2 uses an active-high NCS); one is driven per
//            frame by a bit-level SPI master task. A register-file model
//            answers reads and expected strobes/MISO bytes are derived from
//            the frame contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;

  localparam int H = 8;  // SCK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       sck   [4];
  logic       ncs   [4];
  logic       mosi;
  logic       miso  [4];
  logic       misoe [4];
  logic       wren  [4];
  logic       rden  [4];
  logic       busy  [4];
  logic       abrt  [4];
  logic [6:0] addr  [4];
  logic [7:0] wdat  [4];
  logic [7:0] rdd   [4];

  logic [7:0]  mem [128];
  logic [16:0] wr_log[$];
  logic [8:0]  rd_log[$];
  int          abort_cnt [4] = '{0, 0, 0, 0};
  int          both_cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  tb_tx [16];
  logic [7:0]  tb_rx [16];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_reg_slave #(
        .CSpiMode (g),
        .CNcsPol  (g == 2)
      ) u_dut (
        .AClkH      (clk),
        .AResetH    (rst),
        .ASckI      (sck[g]),
        .ANcsI      (ncs[g]),
        .AMosi      (mosi),
        .AMiso      (miso[g]),
        .AMisoE     (misoe[g]),
        .ARegAddr   (addr[g]),
        .ARegWrData (wdat[g]),
        .ARegWrEn   (wren[g]),
        .ARegRdEn   (rden[g]),
        .ARegRdData (rdd[g]),
        .ABusy      (busy[g]),
        .AAbort     (abrt[g])
      );
    end
  endgenerate

  // Register file: data valid exactly one cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      rdd[i] <= (rden[i] === 1'b1) ? mem[addr[i]] : 8'h00;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wren[i] === 1'b1) wr_log.push_back({2'(i), addr[i], wdat[i]});
      if (rden[i] === 1'b1) rd_log.push_back({2'(i), addr[i]});
      if (wren[i] === 1'b1 && rden[i] === 1'b1) both_cnt++;
      if (abrt[i] === 1'b1) abort_cnt[i]++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic pol(input int m);
    return (m == 2);
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sck(input int m, input logic lvl);
    sck[m] = lvl ^ m[1];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] out_vec(input int m);
    return {miso[m], misoe[m], addr[m], wdat[m], wren[m], rden[m], busy[m], abrt[m]};
  endfunction

  // Shift nbits of tb_tx out MSB first, capturing MISO where the master
  // would sample it. keep=1 leaves NCS active at the end.
  task automatic run_frame(input int m, input int nbits, input bit keep);
    logic b;
    for (int i = 0; i < 16; i++) tb_rx[i] = 8'h00;
    ncs[m] = pol(m);
    ticks(6);
    for (int bi = 0; bi < nbits; bi++) begin
      b = tb_tx[bi / 8][7 - (bi % 8)];
      if (m[0] == 1'b0) begin
        mosi = b;
        ticks(H);
        tb_rx[bi / 8] = {tb_rx[bi / 8][6:0], miso[m]};
        set_sck(m, 1'b1);
        ticks(H);
        set_sck(m, 1'b0);
      end else begin
        set_sck(m, 1'b1);
        mosi = b;
        ticks(H);
        tb_rx[bi / 8] = {tb_rx[bi / 8][6:0], miso[m]};
        set_sck(m, 1'b0);
        ticks(H);
      end
    end
    ticks(6);
    if (!keep) begin
      ncs[m] = ~pol(m);
      ticks(12);
    end
  endtask

  // Expected behaviour from the frame contents: command byte {rd, addr};
  // write frames write each full data byte at addr, addr+1, ...; read frames
  // read addr..addr+ndata (one prefetch beyond the last byte) and return
  // 0x00 during the command byte followed by the register contents.
  task automatic check_frame(input string tag, input int m, input int nbits, input int ab0);
    int         nfull;
    logic [6:0] a;
    logic       isrd;
    logic [7:0] exp;
    nfull = nbits / 8;
    a     = tb_tx[0][6:0];
    isrd  = tb_tx[0][7];
    if (isrd) begin
      check({tag, "_nrd"}, rd_log.size(), nfull);
      check({tag, "_nwr"}, wr_log.size(), 0);
      for (int i = 0; i < nfull && i < rd_log.size(); i++)
        check({tag, "_rdaddr"}, rd_log[i], {m[1:0], 7'(a + i)});
    end else begin
      check({tag, "_nwr"}, wr_log.size(), nfull - 1);
      check({tag, "_nrd"}, rd_log.size(), 0);
      for (int i = 0; i < nfull - 1 && i < wr_log.size(); i++)
        check({tag, "_wr"}, wr_log[i], {m[1:0], 7'(a + i), tb_tx[i + 1]});
    end
    for (int i = 0; i < nfull; i++) begin
      exp = (isrd && i > 0) ? mem[7'(a + i - 1)] : 8'h00;
      check({tag, "_miso"}, tb_rx[i], exp);
    end
    check({tag, "_abort"}, abort_cnt[m] - ab0, ((nbits % 8) != 0) ? 1 : 0);
    check({tag, "_busy"}, {busy[m], misoe[m]}, 2'b00);
    check({tag, "_both"}, both_cnt, 0);
    wr_log.delete();
    rd_log.delete();
  endtask

  initial begin
    int ab;
    int m;
    int nd;

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      sck[i] = i[1];
      ncs[i] = ~pol(i);
    end
    mosi = 1'b0;
    rst  = 1'b1;
    ticks(4);
    for (int i = 0; i < 4; i++) check("reset_outputs", out_vec(i), 21'd0);
    rst = 1'b0;
    ticks(8);

    // Mode 0 write with address increment
    tb_tx[0] = 8'h05; tb_tx[1] = 8'hA1; tb_tx[2] = 8'hB2;
    ab = abort_cnt[0];
    run_frame(0, 24, 1'b0);
    check_frame("m0_write", 0, 24, ab);

    // Mode 0 read with prefetch
    mem[16] = 8'h3C; mem[17] = 8'h5A;
    tb_tx[0] = 8'h90; tb_tx[1] = 8'h00; tb_tx[2] = 8'h00;
    ab = abort_cnt[0];
    run_frame(0, 24, 1'b0);
    check_frame("m0_read", 0, 24, ab);

    // Address wrap 0x7F -> 0x00
    tb_tx[0] = 8'h7F; tb_tx[1] = 8'h11; tb_tx[2] = 8'h22;
    ab = abort_cnt[0];
    run_frame(0, 24, 1'b0);
    check_frame("wrap", 0, 24, ab);

    // Abort after 3 bits of the second data byte
    tb_tx[0] = 8'h20; tb_tx[1] = 8'h44; tb_tx[2] = 8'hE7;
    ab = abort_cnt[0];
    run_frame(0, 19, 1'b0);
    check_frame("abort", 0, 19, ab);

    // Command-only frames
    tb_tx[0] = 8'h33;
    ab = abort_cnt[1];
    run_frame(1, 8, 1'b0);
    check_frame("cmd_only_wr", 1, 8, ab);
    tb_tx[0] = 8'hB3;
    ab = abort_cnt[1];
    run_frame(1, 8, 1'b0);
    check_frame("cmd_only_rd", 1, 8, ab);

    // Modes 3, 1, 2: read 0x81 returning 0xC3
    mem[1] = 8'hC3;
    tb_tx[0] = 8'h81; tb_tx[1] = 8'h00;
    ab = abort_cnt[3];
    run_frame(3, 16, 1'b0);
    check_frame("m3_read", 3, 16, ab);
    ab = abort_cnt[1];
    run_frame(1, 16, 1'b0);
    check_frame("m1_read", 1, 16, ab);
    ab = abort_cnt[2];
    run_frame(2, 16, 1'b0);
    check_frame("m2_read", 2, 16, ab);

    // Randomized frames on random modes
    for (int f = 0; f < 10; f++) begin
      m  = $urandom_range(0, 3);
      nd = $urandom_range(0, 3);
      for (int i = 0; i <= nd; i++) tb_tx[i] = 8'($urandom);
      ab = abort_cnt[m];
      run_frame(m, 8 * (nd + 1), 1'b0);
      check_frame("random", m, 8 * (nd + 1), ab);
    end

    // Reset in the middle of a read frame, NCS kept active across it
    tb_tx[0] = 8'h85; tb_tx[1] = 8'hFF;
    run_frame(0, 12, 1'b1);
    check("midrst_prefetch", rd_log.size(), 1);
    wr_log.delete();
    rd_log.delete();
    ab = abort_cnt[0];
    rst = 1'b1;
    ticks(1);
    check("midrst_outputs", out_vec(0), 21'd0);
    ticks(2);
    rst = 1'b0;
    ticks(6);
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      set_sck(0, i[0] ? 1'b0 : 1'b1);
      ticks(H);
    end
    check("midrst_no_wr", wr_log.size(), 0);
    check("midrst_no_rd", rd_log.size(), 0);
    check("midrst_no_abort", abort_cnt[0] - ab, 0);
    check("midrst_busy", busy[0], 1'b0);
    ncs[0] = 1'b1;
    ticks(12);

    // Normal operation resumes after the next NCS activation
    tb_tx[0] = 8'h41; tb_tx[1] = 8'h9D;
    ab = abort_cnt[0];
    run_frame(0, 16, 1'b0);
    check_frame("after_rst", 0, 16, ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
